// File: rtl/rggen_bit_field_event_capture_pkg.sv
// Shared encodings for the event-capture bit field, used by the register
// generator templates and by the cell/top RTL.
package rggen_bit_field_event_capture_pkg;

   localparam int RGGEN_W1C = 0;
   localparam int RGGEN_RC  = 1;

   typedef enum logic {
      CLEAR_W1C = 1'b0,
      CLEAR_RC  = 1'b1
   } clear_mode_e;

   function automatic clear_mode_e to_clear_mode(input int mode);
      return (mode == RGGEN_RC) ? CLEAR_RC : CLEAR_W1C;
   endfunction

endpackage

// File: rtl/rggen_event_capture_cell.sv
// Single-bit event capture slice: sticky pending flag, lost-event flag and
// a one-cycle acknowledge for software clears.
module rggen_event_capture_cell #(
   parameter logic INITIAL_VALUE = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_event,
   output logic o_pending,
   output logic o_overflow,
   output logic o_ack
);

   logic pending_q, pending_d;
   logic overflow_q, overflow_d;
   logic ack_q, ack_d;

   // A new event in the same cycle as a clear replaces the old occurrence:
   // pending stays set, nothing is lost, and no ack is given for it.
   always_comb begin
      pending_d  = (pending_q & ~i_clr) | i_event;
      overflow_d = (overflow_q & ~i_clr) | (i_event & pending_q & ~i_clr);
      ack_d      = i_clr & pending_q & ~i_event;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pending_q  <= INITIAL_VALUE;
         overflow_q <= 1'b0;
         ack_q      <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
         ack_q      <= ack_d;
      end
   end

   assign o_pending  = pending_q;
   assign o_overflow = overflow_q;
   assign o_ack      = ack_q;

endmodule

// File: rtl/rggen_bit_field_event_capture.sv
// Hardware-to-software event capture bit field: latches per-bit event
// pulses, lets software clear them (W1C or RC) and raises a maskable irq.
module rggen_bit_field_event_capture
   import rggen_bit_field_event_capture_pkg::*;
#(
   parameter int               WIDTH         = 8,
   parameter int               CLEAR_MODE    = RGGEN_W1C,
   parameter logic [WIDTH-1:0] INITIAL_VALUE = {WIDTH{1'b0}}
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_bit_field_valid,
   input  logic [WIDTH-1:0] i_bit_field_read_mask,
   input  logic [WIDTH-1:0] i_bit_field_write_mask,
   input  logic [WIDTH-1:0] i_bit_field_write_data,
   output logic [WIDTH-1:0] o_bit_field_read_data,
   output logic [WIDTH-1:0] o_bit_field_value,
   input  logic [WIDTH-1:0] i_event,
   input  logic [WIDTH-1:0] i_irq_enable,
   output logic [WIDTH-1:0] o_pending,
   output logic [WIDTH-1:0] o_overflow,
   output logic [WIDTH-1:0] o_ack,
   output logic             o_irq
);

   localparam clear_mode_e MODE = to_clear_mode(CLEAR_MODE);

   logic             is_read;
   logic [WIDTH-1:0] clr_w1c;
   logic [WIDTH-1:0] clr_rc;
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] pending;

   // An access with an all-zero write mask is a read.
   always_comb begin
      is_read = i_bit_field_valid && (i_bit_field_write_mask == '0);
      clr_w1c = i_bit_field_valid ? (i_bit_field_write_mask & i_bit_field_write_data) : '0;
      clr_rc  = is_read ? i_bit_field_read_mask : '0;
      clr     = (MODE == CLEAR_RC) ? clr_rc : clr_w1c;
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      rggen_event_capture_cell #(
         .INITIAL_VALUE (INITIAL_VALUE[i])
      ) u_cell (
         .i_clk      (i_clk),
         .i_rst_n    (i_rst_n),
         .i_clr      (clr[i]),
         .i_event    (i_event[i]),
         .o_pending  (pending[i]),
         .o_overflow (o_overflow[i]),
         .o_ack      (o_ack[i])
      );
   end

   // Read data is the flop value, i.e. what was pending before this access clears it.
   assign o_bit_field_read_data = pending;
   assign o_bit_field_value     = pending;
   assign o_pending             = pending;
   assign o_irq                 = |(pending & i_irq_enable);

endmodule

// File: tb/tb_rggen_bit_field_event_capture.sv
// Bench for the event-capture bit field: one W1C and one RC instance share
// the same access/event stream and are compared against a rule-level model.
module tb_rggen_bit_field_event_capture;

  localparam int W = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         valid;
  logic [W-1:0] rmask, wmask, wdata, ev, irq_en;

  logic [W-1:0] a_rd, a_val, a_pend, a_ovf, a_ack;
  logic         a_irq;
  logic [W-1:0] b_rd, b_val, b_pend, b_ovf, b_ack;
  logic         b_irq;

  rggen_bit_field_event_capture #(
    .WIDTH(W), .CLEAR_MODE(0), .INITIAL_VALUE(8'h11)
  ) dut_w1c (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_bit_field_valid(valid), .i_bit_field_read_mask(rmask),
    .i_bit_field_write_mask(wmask), .i_bit_field_write_data(wdata),
    .o_bit_field_read_data(a_rd), .o_bit_field_value(a_val),
    .i_event(ev), .i_irq_enable(irq_en),
    .o_pending(a_pend), .o_overflow(a_ovf), .o_ack(a_ack), .o_irq(a_irq)
  );

  rggen_bit_field_event_capture #(
    .WIDTH(W), .CLEAR_MODE(1), .INITIAL_VALUE(8'h00)
  ) dut_rc (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_bit_field_valid(valid), .i_bit_field_read_mask(rmask),
    .i_bit_field_write_mask(wmask), .i_bit_field_write_data(wdata),
    .o_bit_field_read_data(b_rd), .o_bit_field_value(b_val),
    .i_event(ev), .i_irq_enable(irq_en),
    .o_pending(b_pend), .o_overflow(b_ovf), .o_ack(b_ack), .o_irq(b_irq)
  );

  // reference model: index 0 = W1C instance, 1 = RC instance
  logic [W-1:0] m_pend[2];
  logic [W-1:0] m_ovf[2];
  logic [W-1:0] m_ack[2];
  logic [W-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_val("a_pending",   a_pend, m_pend[0]);
    check_val("a_value",     a_val,  m_pend[0]);
    check_val("a_read_data", a_rd,   m_pend[0]);
    check_val("a_overflow",  a_ovf,  m_ovf[0]);
    check_val("a_ack",       a_ack,  m_ack[0]);
    check_val("a_irq", {7'b0, a_irq}, {7'b0, (m_pend[0] & irq_en) != 0});
    check_val("b_pending",   b_pend, m_pend[1]);
    check_val("b_value",     b_val,  m_pend[1]);
    check_val("b_read_data", b_rd,   m_pend[1]);
    check_val("b_overflow",  b_ovf,  m_ovf[1]);
    check_val("b_ack",       b_ack,  m_ack[1]);
    check_val("b_irq", {7'b0, b_irq}, {7'b0, (m_pend[1] & irq_en) != 0});
  endtask

  // Per-bit rules: which bits does this access clear, then what happens to
  // each bit given (clear, event) and its current state.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic [W-1:0] c;
      c = '0;
      if (k == 0) begin
        if (valid) c = wmask & wdata;
      end else begin
        if (valid && wmask == '0) c = rmask;
      end
      for (int i = 0; i < W; i++) begin
        if (c[i] && ev[i]) begin
          m_pend[k][i] = 1'b1; m_ovf[k][i] = 1'b0; m_ack[k][i] = 1'b0;
        end else if (c[i]) begin
          m_ack[k][i] = m_pend[k][i]; m_pend[k][i] = 1'b0; m_ovf[k][i] = 1'b0;
        end else if (ev[i]) begin
          if (m_pend[k][i]) m_ovf[k][i] = 1'b1;
          m_pend[k][i] = 1'b1; m_ack[k][i] = 1'b0;
        end else begin
          m_ack[k][i] = 1'b0;
        end
      end
    end
  endtask

  task automatic model_reset();
    m_pend[0] = 8'h11; m_pend[1] = 8'h00;
    for (int k = 0; k < 2; k++) begin
      m_ovf[k] = '0; m_ack[k] = '0;
    end
  endtask

  // driver: called at a negedge, applies one cycle of inputs, checks after the edge
  task automatic tick(input logic v, input logic [W-1:0] rm, input logic [W-1:0] wm,
                      input logic [W-1:0] wd, input logic [W-1:0] e);
    valid = v; rmask = rm; wmask = wm; wdata = wd; ev = e;
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    tick(1'b0, '0, '0, '0, '0);
  endtask

  task automatic random_phase(input int n);
    for (int t = 0; t < n; t++) begin
      logic         v;
      logic [W-1:0] rm, wm, wd, e;
      if ($urandom_range(0, 15) == 0) irq_en = W'($urandom);
      v  = ($urandom_range(0, 2) != 0);
      rm = W'($urandom);
      wm = ($urandom_range(0, 1) == 0) ? '0 : W'($urandom);
      wd = W'($urandom);
      e  = W'($urandom) & W'($urandom);
      tick(v, rm, wm, wd, e);
    end
  endtask

  initial begin
    valid = 1'b0; rmask = '0; wmask = '0; wdata = '0; ev = '0; irq_en = 8'h01;
    model_reset();
    repeat (2) @(negedge clk);
    check_val("reset_a_pending", a_pend, 8'h11);
    check_val("reset_a_irq", {7'b0, a_irq}, 8'h01);
    check_val("reset_b_pending", b_pend, 8'h00);
    rst_n = 1'b1;
    check_outputs();

    // W1C basic
    irq_en = 8'h00;
    tick(1'b1, '0, 8'hFF, 8'hFF, '0);
    check_val("init_clear_ack", a_ack, 8'h11);
    tick(1'b0, '0, '0, '0, 8'h05);
    check_val("evt05_pending", a_pend, 8'h05);
    tick(1'b1, 8'hFF, '0, '0, '0);
    check_val("w1c_read_keeps", a_rd, 8'h05);
    check_val("rc_read_clears", b_pend, 8'h00);
    check_val("rc_read_ack", b_ack, 8'h05);
    tick(1'b1, '0, 8'hFF, 8'h01, '0);
    check_val("w1c_clear_pending", a_pend, 8'h04);
    check_val("w1c_clear_ack", a_ack, 8'h01);
    idle();
    check_val("w1c_ack_one_cycle", a_ack, 8'h00);

    // overflow
    tick(1'b1, '0, 8'hFF, 8'hFF, '0);
    tick(1'b0, '0, '0, '0, 8'h08);
    idle();
    tick(1'b0, '0, '0, '0, 8'h08);
    check_val("ovf_set", a_ovf, 8'h08);
    tick(1'b1, '0, 8'hFF, 8'h08, '0);
    check_val("ovf_clr_pending", a_pend, 8'h00);
    check_val("ovf_clr_ovf", a_ovf, 8'h00);
    check_val("ovf_clr_ack", a_ack, 8'h08);

    // simultaneous event and clear
    tick(1'b0, '0, '0, '0, 8'h80);
    tick(1'b1, '0, 8'hFF, 8'h80, 8'h80);
    check_val("simul_pending", a_pend, 8'h80);
    check_val("simul_ovf", a_ovf, 8'h00);
    check_val("simul_ack", a_ack, 8'h00);

    // read-to-clear instance
    tick(1'b1, 8'hFF, '0, '0, '0);
    tick(1'b0, '0, '0, '0, 8'h30);
    check_val("rc_read_data", b_rd, 8'h30);
    tick(1'b1, 8'hFF, '0, '0, '0);
    check_val("rc_pending_cleared", b_pend, 8'h00);
    check_val("rc_ack", b_ack, 8'h30);
    tick(1'b0, '0, '0, '0, 8'h30);
    tick(1'b1, '0, 8'hFF, 8'hFF, '0);
    check_val("rc_write_ignored", b_pend, 8'h30);

    // interrupt
    irq_en = 8'h02;
    tick(1'b1, '0, 8'hFF, 8'hFF, '0);
    tick(1'b1, 8'hFF, '0, '0, '0);
    tick(1'b0, '0, '0, '0, 8'h01);
    check_val("irq_masked", {7'b0, a_irq}, 8'h00);
    tick(1'b0, '0, '0, '0, 8'h02);
    check_val("irq_set", {7'b0, a_irq}, 8'h01);
    tick(1'b1, '0, 8'hFF, 8'h02, '0);
    check_val("irq_cleared", {7'b0, a_irq}, 8'h00);

    random_phase(300);

    // reset mid-stream with an ack in flight
    tick(1'b0, '0, '0, '0, 8'hFF);
    tick(1'b0, '0, '0, '0, 8'h0F);
    tick(1'b1, '0, 8'hFF, 8'h01, '0);
    valid = 1'b0; wmask = '0; wdata = '0; ev = '0;
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_a_pending", a_pend, 8'h11);
    check_val("async_rst_a_ovf", a_ovf, 8'h00);
    check_val("async_rst_a_ack", a_ack, 8'h00);
    check_val("async_rst_b_pending", b_pend, 8'h00);
    check_val("async_rst_b_ovf", b_ovf, 8'h00);
    model_reset();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    idle();

    random_phase(300);

    exp_q.delete();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rggen_bit_field_event_capture.md
Name: rggen_bit_field_event_capture

Overview:
- Hardware-to-software bit field; the counterpart of the write-triggered pulse fields.
- Hardware raises per-bit event pulses, which are latched as sticky pending bits.
- Software reads the pending bits and clears them, either write-1-to-clear or read-to-clear.
- The block returns a one-cycle acknowledge pulse to hardware per cleared bit, flags events lost while already pending, and drives a maskable interrupt. It sits in the register block alongside the other rggen_bit_field_* cells.

Parameters:
- WIDTH, 8: number of event bits.
- CLEAR_MODE, 0: 0 = write-1-to-clear, 1 = read-to-clear.
- INITIAL_VALUE, {WIDTH{1'b0}}: pending value after reset.

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_bit_field_valid  input  1  register access strobe, one cycle per access.
- i_bit_field_read_mask  input  WIDTH  bits selected by a read access.
- i_bit_field_write_mask  input  WIDTH  bits selected by a write access; all-zero marks a read access.
- i_bit_field_write_data  input  WIDTH  write data.
- o_bit_field_read_data  output  WIDTH  current pending bits (pre-clear value).
- o_bit_field_value  output  WIDTH  current pending bits.
- i_event  input  WIDTH  per-bit hardware event pulse; level high counts one event per cycle.
- i_irq_enable  input  WIDTH  per-bit interrupt enable, quasi-static.
- o_pending  output  WIDTH  registered pending bits.
- o_overflow  output  WIDTH  sticky per-bit lost-event flag.
- o_ack  output  WIDTH  one-cycle pulse per bit cleared by software.
- o_irq  output  1  OR of (pending & i_irq_enable).

Behaviour:
- Reset (async assert, sync release): pending=INITIAL_VALUE, overflow=0, ack=0. Therefore o_irq=|(INITIAL_VALUE & i_irq_enable).
- Clear vector, combinational, per cycle:
  - CLEAR_MODE=0: clr = i_bit_field_valid ? (write_mask & write_data) : 0. Reads never clear.
  - CLEAR_MODE=1: clr = (i_bit_field_valid && write_mask==0) ? read_mask : 0. Writes are ignored entirely.
- Next-state per bit i, registered on posedge i_clk:
  - pending_n = (pending & ~clr) | i_event.
  - overflow_n = (overflow & ~clr) | (i_event & pending & ~clr).
  - ack_n = clr & pending & ~i_event.
- Clear of a non-pending bit: no effect, no ack.
- Simultaneous event and clear on the same bit:
  - The event wins and pending stays 1.
  - The old occurrence is consumed, so no overflow is set.
  - No ack is issued, because hardware must not see an ack for an event still pending.
- Event while already pending with no clear: pending stays 1 and overflow sets. Overflow clears only with a clear of that bit.
- Latency:
  - An event at cycle N is visible on o_pending, o_bit_field_value and o_irq at N+1.
  - The read at N+1 returns 1.
  - The clear access at cycle M drops pending at M+1; o_ack is high for exactly cycle M+1.
- o_bit_field_read_data = pending (registered value, before the clear of the same access). Masking is done by the register block.
- o_irq is combinational from pending flops and i_irq_enable. No extra latency; glitch-free w.r.t. i_clk domain.
- Reset mid-operation: all state returns to reset values immediately, and any ack in flight is dropped.
- No internal width arithmetic. All operations are bitwise, WIDTH ≥ 1.

Decomposition:
- Shared package or header: CLEAR_MODE encodings RGGEN_W1C=0 and RGGEN_RC=1, used by the register generator templates.
- One natural sub-module, rggen_event_capture_cell:
  - Single-bit slice holding the pending, overflow and ack flops.
  - Inputs: clr, event.
  - Parameter: bit initial value.
  - The top generates WIDTH instances, builds clr, and ORs the masked pending bits into o_irq.

Test Plan:
- W1C basic, WIDTH=8, CLEAR_MODE=0:
  - Pulse i_event=8'h05 for 1 cycle -> o_pending=8'h05 next cycle.
  - Read -> read_data=8'h05.
  - Write mask=FF data=8'h01 -> pending=8'h04, o_ack=8'h01 for exactly one cycle.
- Overflow:
  - Event bit3 at cycles N and N+2, no clear -> o_overflow[3]=1 from N+3.
  - Write-1-clear bit3 -> pending[3]=0, overflow[3]=0, ack[3]=1.
- Simultaneous event and clear:
  - Pending=8'h80; event bit7 in the same cycle as write-1 to bit7 -> pending stays 8'h80, overflow=0, ack=0.
- Read-clear, CLEAR_MODE=1:
  - Pending=8'h30; read with read_mask=8'hFF -> read_data=8'h30, next cycle pending=0, ack=8'h30.
  - A write with data=FF in this mode -> no change.
- Interrupt:
  - i_irq_enable=8'h02, event bit0 -> o_irq stays 0.
  - Event bit1 -> o_irq=1 the next cycle.
  - Clear bit1 -> o_irq=0 the cycle after.
- Reset:
  - INITIAL_VALUE=8'h11; assert i_rst_n low mid-stream with pending=8'hFF, overflow=8'h0F -> outputs asynchronously go to pending=8'h11, overflow=0, ack=0.
